// File: rtl/ysyx_23060184_wbu.sv
// Writeback unit: a 2-entry FIFO between the LSU and the register file.
// Each popped entry produces one registered register-file write and one
// commit pulse. The unit halts permanently after committing an ebreak.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready = count < 2)
//   in_rd, in_rd_wen         destination register and write enable
//   in_wbsel                 00 ALU, 01 LOAD, 10 PC+4, 11 CSR
//   in_alu/pc/csr/ldata      candidate result sources
//   in_lfunct3, in_laddr_lo  load size/sign and byte offset
//   in_ebreak                entry is an ebreak
//   wb_hold                  stall popping
//   rf_*                     register-file write port (registered)
//   commit_valid/commit_pc   retirement pulse and PC (registered)
//   halt, retire_cnt         sticky halt flag, retired-instruction counter
module ysyx_23060184_wbu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [1:0]            in_wbsel,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_csr,
    input  logic [DATA_WIDTH-1:0] in_ldata,
    input  logic [2:0]            in_lfunct3,
    input  logic [1:0]            in_laddr_lo,
    input  logic                  in_ebreak,
    input  logic                  wb_hold,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wvalid,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic                  halt,
    output logic [31:0]           retire_cnt
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    // Entries store the already-selected writeback value, not the raw sources.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic                  rd_wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] pc;
        logic                  ebreak;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            halt_q, halt_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    logic            rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic            rf_wvalid_q, rf_wvalid_d;
    logic            commit_valid_q, commit_valid_d;
    logic [DATA_WIDTH-1:0] commit_pc_q, commit_pc_d;

    logic            push;
    logic            pop;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] wb_value;
    entry_t          new_entry;
    entry_t          head;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !wb_hold && !halt_q;

    // Load extraction; halfword select ignores address bit 0.
    always_comb begin : load_extend
        ld_byte  = in_ldata[{in_laddr_lo, 3'b000} +: 8];
        ld_half  = in_ldata[{in_laddr_lo[1], 4'b0000} +: 16];
        load_ext = in_ldata;
        case (in_lfunct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  load_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_ext = in_ldata;
        endcase
    end

    // Writeback source select.
    always_comb begin : wb_select
        wb_value = in_alu;
        case (in_wbsel)
            2'b00:   wb_value = in_alu;
            2'b01:   wb_value = load_ext;
            2'b10:   wb_value = in_pc + DATA_WIDTH'(4);
            default: wb_value = in_csr;
        endcase
        new_entry.rd     = in_rd;
        new_entry.rd_wen = in_rd_wen;
        new_entry.wdata  = wb_value;
        new_entry.pc     = in_pc;
        new_entry.ebreak = in_ebreak;
    end

    // FIFO bookkeeping and registered write/commit outputs.
    always_comb begin : next_state
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        halt_d         = halt_q;
        retire_cnt_d   = retire_cnt_q;
        rf_wvalid_d    = 1'b0;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        head           = mem_q[rd_ptr_q];

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d       = ~rd_ptr_q;
            rf_wvalid_d    = 1'b1;
            rf_wen_d       = head.rd_wen && (head.rd != '0);
            rf_waddr_d     = head.rd;
            rf_wdata_d     = head.wdata;
            commit_valid_d = 1'b1;
            commit_pc_d    = head.pc;
            retire_cnt_d   = retire_cnt_q + 32'd1;
            if (head.ebreak) begin
                halt_d = 1'b1;
            end
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control and output registers; reset discards buffered entries.
    always_ff @(posedge clk) begin : state_regs
        if (reset) begin
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
            halt_q         <= 1'b0;
            retire_cnt_q   <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            rf_wvalid_q    <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            halt_q         <= halt_d;
            retire_cnt_q   <= retire_cnt_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_wvalid_q    <= rf_wvalid_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin : payload_regs
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_wvalid    = rf_wvalid_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign halt         = halt_q;
    assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Testbench for ysyx_23060184_wbu: directed cases plus random traffic,
// with a scoreboard queue filled by the driver and drained by a monitor.
module tb_ysyx_23060184_wbu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [1:0]  in_wbsel;
    logic [31:0] in_alu, in_pc, in_csr, in_ldata;
    logic [2:0]  in_lfunct3;
    logic [1:0]  in_laddr_lo;
    logic        in_ebreak;
    logic        wb_hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wvalid;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        halt;
    logic [31:0] retire_cnt;

    ysyx_23060184_wbu dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_wbsel(in_wbsel),
        .in_alu(in_alu), .in_pc(in_pc), .in_csr(in_csr), .in_ldata(in_ldata),
        .in_lfunct3(in_lfunct3), .in_laddr_lo(in_laddr_lo), .in_ebreak(in_ebreak),
        .wb_hold(wb_hold),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wvalid(rf_wvalid),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .halt(halt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        logic [31:0] alu, pc, csr, ld;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        eb;
    } stim_t;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        eb;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] seed_val = 32'd0;
    int          seed_gen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the architectural rules, using plain arithmetic.
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] b, h, ldv;
        b = (s.ld >> (8 * s.lo)) & 32'hFF;
        h = (s.ld >> (16 * (s.lo / 2))) & 32'hFFFF;
        case (s.f3)
            3'd0:    ldv = (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    ldv = b;
            3'd1:    ldv = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    ldv = h;
            default: ldv = s.ld;
        endcase
        case (s.sel)
            2'd0:    e.data = s.alu;
            2'd1:    e.data = ldv;
            2'd2:    e.data = s.pc + 32'd4;
            default: e.data = s.csr;
        endcase
        e.wen  = s.wen && (s.rd != 5'd0);
        e.addr = s.rd;
        e.pc   = s.pc;
        e.eb   = s.eb;
        return e;
    endfunction

    function automatic stim_t mk(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                                 input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] lo);
        stim_t s;
        s.rd = rd; s.wen = 1'b1; s.sel = sel; s.pc = pc; s.f3 = f3; s.lo = lo; s.eb = 1'b0;
        s.alu = val; s.csr = ~val; s.ld = val;
        return s;
    endfunction

    // Present one entry at a negedge; the next posedge samples it.
    task automatic drive(input stim_t s, output bit acc);
        in_valid = 1'b1; in_rd = s.rd; in_rd_wen = s.wen; in_wbsel = s.sel;
        in_alu = s.alu; in_pc = s.pc; in_csr = s.csr; in_ldata = s.ld;
        in_lfunct3 = s.f3; in_laddr_lo = s.lo; in_ebreak = s.eb;
        acc = in_ready;
        if (acc) exp_q.push_back(model(s));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) rst_at_edge <= reset;

    // Monitor: compares every presented commit against the scoreboard.
    initial begin : monitor
        exp_t        e;
        logic [31:0] m_retire = 32'd0;
        logic        m_halt = 1'b0;
        int          seen_gen = 0;
        forever begin
            @(negedge clk);
            if (seed_gen != seen_gen) begin
                m_retire = seed_val;
                seen_gen = seed_gen;
            end
            if (rst_at_edge) begin
                exp_q.delete();
                m_retire = 32'd0;
                m_halt   = 1'b0;
                check("rst_wvalid", 32'(rf_wvalid), 32'd0);
                check("rst_cvalid", 32'(commit_valid), 32'd0);
                check("rst_wen", 32'(rf_wen), 32'd0);
                check("rst_waddr", 32'(rf_waddr), 32'd0);
                check("rst_wdata", rf_wdata, 32'd0);
                check("rst_cpc", commit_pc, 32'd0);
                check("rst_halt", 32'(halt), 32'd0);
                check("rst_retire", retire_cnt, 32'd0);
                check("rst_ready", 32'(in_ready), 32'd1);
            end else begin
                check("cvalid_eq_wvalid", 32'(commit_valid), 32'(rf_wvalid));
                if (!rf_wvalid) begin
                    check("wen_idle", 32'(rf_wen), 32'd0);
                end else if (m_halt) begin
                    check("commit_after_halt", 32'(rf_wvalid), 32'd0);
                end else if (exp_q.size() == 0) begin
                    check("commit_unexpected", 32'(rf_wvalid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    m_retire = m_retire + 32'd1;
                    check("sb_wen", 32'(rf_wen), 32'(e.wen));
                    check("sb_waddr", 32'(rf_waddr), 32'(e.addr));
                    check("sb_wdata", rf_wdata, e.data);
                    check("sb_pc", commit_pc, e.pc);
                    check("sb_retire", retire_cnt, m_retire);
                    if (e.eb) m_halt = 1'b1;
                end
                check("halt", 32'(halt), 32'(m_halt));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        stim_t s;
        bit    acc;
        int    nacc;
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_wbsel = '0;
        in_alu = '0; in_pc = '0; in_csr = '0; in_ldata = '0; in_lfunct3 = '0;
        in_laddr_lo = '0; in_ebreak = 1'b0; wb_hold = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Single ALU write: commit visible in the cycle after the pop edge.
        drive(mk(2'd0, 5'd5, 32'h1234_5678, 32'h8000_0000, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        @(negedge clk);
        check("alu_wvalid", 32'(rf_wvalid), 32'd1);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        check("alu_retire", retire_cnt, 32'd1);
        idle(2);

        // Load extension cases and PC+4 wrap, back to back.
        drive(mk(2'd1, 5'd6, 32'h80FF_7F01, 32'h100, 3'd0, 2'd1), acc);
        drive(mk(2'd1, 5'd7, 32'h80FF_7F01, 32'h104, 3'd4, 2'd2), acc);
        drive(mk(2'd1, 5'd8, 32'h80FF_7F01, 32'h108, 3'd1, 2'd2), acc);
        drive(mk(2'd1, 5'd9, 32'h80FF_7F01, 32'h10C, 3'd5, 2'd0), acc);
        drive(mk(2'd1, 5'd9, 32'h80FF_7F01, 32'h110, 3'd1, 2'd3), acc);
        drive(mk(2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        @(negedge clk);
        check("pc4_wrap", rf_wdata, 32'h0000_0000);
        drive(mk(2'd3, 5'd0, 32'hDEAD_BEEF, 32'h200, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        @(negedge clk);
        check("rd0_wvalid", 32'(rf_wvalid), 32'd1);
        check("rd0_wen", 32'(rf_wen), 32'd0);
        idle(2);

        // Hold: third push is refused, then two commits drain in order.
        wb_hold = 1'b1;
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(2'd0, 5'(10 + i), 32'hA000_0000 + 32'(i), 32'h300 + 32'(4 * i), 3'd2, 2'd0), acc);
            nacc += int'(acc);
        end
        in_valid = 1'b0;
        check("hold_accepted", 32'(nacc), 32'd2);
        check("hold_ready", 32'(in_ready), 32'd0);
        check("hold_no_commit", 32'(rf_wvalid), 32'd0);
        wb_hold = 1'b0;
        @(negedge clk);
        check("drain_first", 32'(rf_wvalid), 32'd1);
        check("drain_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("drain_second", 32'(rf_wvalid), 32'd1);
        @(negedge clk);
        check("drain_done", 32'(rf_wvalid), 32'd0);

        // Retire counter wrap via backdoor preset.
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        seed_val = 32'hFFFF_FFFF;
        seed_gen++;
        @(negedge clk);
        release dut.retire_cnt_q;
        @(negedge clk);
        check("retire_preset", retire_cnt, 32'hFFFF_FFFF);
        drive(mk(2'd0, 5'd3, 32'h5555_AAAA, 32'h400, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        @(negedge clk);
        check("retire_wrap", retire_cnt, 32'd0);
        idle(2);

        // Random traffic with random stalls.
        for (int i = 0; i < 250; i++) begin
            s.rd = 5'($urandom_range(0, 31)); s.wen = 1'($urandom);
            s.sel = 2'($urandom); s.alu = $urandom; s.pc = $urandom;
            s.csr = $urandom; s.ld = $urandom; s.f3 = 3'($urandom);
            s.lo = 2'($urandom); s.eb = 1'b0;
            wb_hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) drive(s, acc);
            else idle(1);
        end
        wb_hold = 1'b0;
        idle(5);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Ebreak halts; later entries stay buffered until reset.
        s = mk(2'd0, 5'd4, 32'hE000_0001, 32'h500, 3'd2, 2'd0);
        s.eb = 1'b1;
        drive(s, acc);
        drive(mk(2'd0, 5'd11, 32'hE000_0002, 32'h504, 3'd2, 2'd0), acc);
        drive(mk(2'd0, 5'd12, 32'hE000_0003, 32'h508, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("halted_ready", 32'(in_ready), 32'd0);
            check("halted_flag", 32'(halt), 32'd1);
            @(negedge clk);
        end
        drive(mk(2'd0, 5'd13, 32'hE000_0004, 32'h50C, 3'd2, 2'd0), acc);
        in_valid = 1'b0;
        check("halted_refuse", 32'(acc), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_halt", 32'(halt), 32'd0);
        check("post_reset_retire", retire_cnt, 32'd0);
        check("post_reset_ready", 32'(in_ready), 32'd1);
        drive(mk(2'd0, 5'd2, 32'h0BAD_F00D, 32'h600, 3'd2, 2'd0), acc);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
